// File: rtl/cellnet_rx_port.sv
// cellnet_rx_port: two-phase req/ack receiver with address filter, sequence check and output FIFO.
// Latency: ack toggles 4 edges after the request is first sampled; data visible on o_dat after the push edge.
// Backpressure: a full FIFO withholds the ack; the consumer pops with o_valid & i_ready.
module cellnet_rx_port #(
  parameter int DATA_SIZE  = 4,
  parameter int ADDR_SIZE  = 4,
  parameter int MY_ADDR    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req,
  input  logic [ADDR_SIZE-1:0]          i_addr,
  input  logic [DATA_SIZE-1:0]          i_dat,
  output logic                          o_ack,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_SIZE-1:0]          o_dat,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_err,
  output logic                          o_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        PTR_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DATA_SIZE-1:0] DAT_ONE = {{(DATA_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] ADDR_ME = ADDR_SIZE'(MY_ADDR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 req_s_q;
  logic                 ack_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] dat_q;
  logic [DATA_SIZE-1:0] last_q;
  logic                 first_q;
  logic                 err_q;
  logic                 drop_q;

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]        wr_q;
  logic [CW-1:0]        rd_q;
  logic [CW-1:0]        wr_ptr_d;
  logic [CW-1:0]        rd_ptr_d;
  logic [DATA_SIZE-1:0] head_q;
  logic [DATA_SIZE-1:0] head_d;

  logic                 pending;
  logic                 full;
  logic                 addr_match;
  logic                 push;
  logic                 pop;
  logic [CW-1:0]        count;
  logic [DATA_SIZE-1:0] exp_dat;

  assign count      = wr_q - rd_q;
  // Occupancy equals FIFO_DEPTH exactly when the pointer difference reaches its MSB.
  assign full       = count[CW-1];
  assign pending    = req_s_q ^ ack_q;
  assign addr_match = (addr_q == ADDR_ME);
  assign push       = (state_q == CAPTURE) && addr_match;
  assign pop        = (wr_q != rd_q) && i_ready;
  assign exp_dat    = last_q + DAT_ONE;

  // Two-flop synchronizer for the foreign-domain request toggle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      req_s_q <= 1'b0;
    end else begin
      sync1_q <= i_req;
      req_s_q <= sync1_q;
    end
  end

  // Handshake FSM: capture the message, filter/check it, then return the ack toggle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      last_q  <= '0;
      first_q <= 1'b1;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // addr/dat are safe to sample: the source holds them while the toggle is outstanding.
          if (pending && !full) begin
            addr_q  <= i_addr;
            dat_q   <= i_dat;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (addr_match) begin
            if (!first_q && (dat_q != exp_dat)) begin
              err_q <= 1'b1;
            end
            last_q  <= dat_q;
            first_q <= 1'b0;
          end else begin
            err_q  <= 1'b1;
            drop_q <= 1'b1;
          end
          state_q <= ACK;
        end
        ACK: begin
          ack_q   <= ~ack_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next pointers and next registered head; a push into a FIFO that is empty after this
  // cycle's pop becomes the head directly, bypassing the memory.
  always_comb begin
    wr_ptr_d = wr_q;
    rd_ptr_d = rd_q;
    head_d   = head_q;
    if (push) wr_ptr_d = wr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_q + PTR_ONE;
    if (push && (wr_q == rd_ptr_d)) begin
      head_d = dat_q;
    end else if (push || pop) begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // FIFO storage; no reset needed since entries are only read once written.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= dat_q;
  end

  // FIFO pointers and registered head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_ptr_d;
      rd_q   <= rd_ptr_d;
      head_q <= head_d;
    end
  end

  assign o_ack   = ack_q;
  assign o_valid = (wr_q != rd_q);
  assign o_dat   = head_q;
  assign o_count = count;
  assign o_err   = err_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_cellnet_rx_port.sv
// Directed bench for cellnet_rx_port with the default parameters (4-bit data/addr, MY_ADDR 0, depth 4).
module tb_cellnet_rx_port;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [3:0] addr;
  logic [3:0] dat;
  logic       ack;
  logic       valid;
  logic       ready;
  logic [3:0] odat;
  logic [2:0] count;
  logic       err;
  logic       drop;

  int total;
  int passed;
  int drop_cnt;
  logic [3:0] rxq[$];

  cellnet_rx_port #(
    .DATA_SIZE(4), .ADDR_SIZE(4), .MY_ADDR(0), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr), .i_dat(dat),
    .o_ack(ack), .o_valid(valid), .i_ready(ready), .o_dat(odat),
    .o_count(count), .o_err(err), .o_drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One cycle: record a pop happening at this edge, then sample 1ns after the edge.
  task automatic tick();
    if (valid && ready) rxq.push_back(odat);
    @(posedge clk);
    #1;
    if (drop) drop_cnt++;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (ack !== req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " ack"}, 32'(ack), 32'(req));
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] d, input string tag);
    addr = a;
    dat  = d;
    req  = ~req;
    wait_ack(tag);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready = 1'b1;
    while (count != 0 && n < 10) begin
      tick();
      n++;
    end
    ready = 1'b0;
  endtask

  task automatic chk_rx(input string tag, input int n, input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] e2, input logic [3:0] e3, input logic [3:0] e4);
    logic [3:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    chk({tag, " popcount"}, 32'(rxq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, " pop"}, (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF, 32'(e[i]));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ack"},   32'(ack),   0);
    chk({tag, " valid"}, 32'(valid), 0);
    chk({tag, " dat"},   32'(odat),  0);
    chk({tag, " count"}, 32'(count), 0);
    chk({tag, " err"},   32'(err),   0);
    chk({tag, " drop"},  32'(drop),  0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rxq.delete();
  endtask

  initial begin
    logic old_ack;
    logic toggled;
    total = 0; passed = 0; drop_cnt = 0;
    clk = 1'b0; rst_n = 1'b0; req = 1'b0; addr = '0; dat = '0; ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single message: ack exactly at E4 (fifth edge after the toggle)
    addr = 4'd0; dat = 4'd5; req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("single ack before E4", 32'(ack), 0);
    tick();
    chk("single ack at E4", 32'(ack), 1);
    chk("single valid", 32'(valid), 1);
    chk("single dat", 32'(odat), 5);
    chk("single count", 32'(count), 1);
    chk("single err", 32'(err), 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("single popped count", 32'(count), 0);
    chk("single popped valid", 32'(valid), 0);

    // Sequence with wrap, consumer always ready
    do_reset();
    ready = 1'b1;
    send(4'd0, 4'd14, "wrap14");
    send(4'd0, 4'd15, "wrap15");
    send(4'd0, 4'd0,  "wrap0");
    send(4'd0, 4'd1,  "wrap1");
    for (int i = 0; i < 3; i++) tick();
    chk_rx("wrap", 4, 4'd14, 4'd15, 4'd0, 4'd1, 4'd0);
    chk("wrap err clean", 32'(err), 0);
    chk("wrap empty", 32'(count), 0);
    send(4'd0, 4'd3, "skip3");
    chk("skip err set", 32'(err), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("skip err sticky", 32'(err), 1);
    ready = 1'b0;
    rxq.delete();

    // Reset in the middle of a message
    addr = 4'd0; dat = 4'd4; req = ~req;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    chk_zero("midreset");
    tick();
    rst_n = 1'b1;
    toggled = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack !== 1'b0) toggled = 1'b1;
    end
    chk("midreset no ack", 32'(toggled), 0);

    // Wrong address
    chk("wrongaddr err before", 32'(err), 0);
    drop_cnt = 0;
    send(4'd2, 4'd7, "wrongaddr");
    tick();
    tick();
    chk("wrongaddr drop pulses", 32'(drop_cnt), 1);
    chk("wrongaddr count", 32'(count), 0);
    chk("wrongaddr valid", 32'(valid), 0);
    chk("wrongaddr err", 32'(err), 1);

    // Backpressure: four fit, fifth held off until a single pop
    rxq.delete();
    ready = 1'b0;
    send(4'd0, 4'd1, "bp1");
    send(4'd0, 4'd2, "bp2");
    send(4'd0, 4'd3, "bp3");
    send(4'd0, 4'd4, "bp4");
    chk("bp count full", 32'(count), 4);
    old_ack = ack;
    addr = 4'd0; dat = 4'd5; req = ~req;
    for (int i = 0; i < 50; i++) tick();
    chk("bp fifth withheld", 32'(ack), 32'(old_ack));
    chk("bp count still full", 32'(count), 4);
    chk("bp head", 32'(odat), 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp count after pop", 32'(count), 3);
    chk("bp head after pop", 32'(odat), 2);
    tick();
    tick();
    chk("bp ack not before 3 edges", 32'(ack), 32'(old_ack));
    chk("bp count refilled", 32'(count), 4);
    tick();
    chk("bp ack 3 edges after pop", 32'(ack), 32'(req));
    drain();
    chk_rx("bp", 5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);

    // Push and pop on the same edge at occupancy 2
    rxq.delete();
    send(4'd0, 4'd6, "pp6");
    send(4'd0, 4'd7, "pp7");
    chk("pp count 2", 32'(count), 2);
    addr = 4'd0; dat = 4'd8; req = ~req;
    for (int i = 0; i < 3; i++) tick();
    chk("pp count before push", 32'(count), 2);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("pp count on push+pop", 32'(count), 2);
    chk("pp head", 32'(odat), 7);
    tick();
    chk("pp ack", 32'(ack), 32'(req));
    chk("pp count after ack", 32'(count), 2);
    drain();
    chk_rx("pp", 3, 4'd6, 4'd7, 4'd8, 4'd0, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
